// File: rtl/fht_ctrl.sv
// Stage/address sequencer for a radix-4 FHT over four ping-ponged RAM banks.
// Optional macro FHT_BITREV_EN: stage-0 read addresses are bit-reversed (natural-order input).
module fht_ctrl #(
   parameter int A_BIT = 8,
   parameter int LAT   = 4
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
   output logic             oST_ZERO,
   output logic             oST_LAST,
   output logic             o2ND_PART_SUBSEC,
   output logic [1:0]       oSECTOR,
   output logic [A_BIT-1:0] oADDR_RD_0,
   output logic [A_BIT-1:0] oADDR_RD_1,
   output logic [A_BIT-1:0] oADDR_RD_2,
   output logic [A_BIT-1:0] oADDR_RD_3,
   output logic [A_BIT-1:0] oADDR_WR_0,
   output logic [A_BIT-1:0] oADDR_WR_1,
   output logic [A_BIT-1:0] oADDR_WR_2,
   output logic [A_BIT-1:0] oADDR_WR_3,
   output logic [A_BIT-1:0] oADDR_COEF,
   output logic             oWE_A,
   output logic             oWE_B,
   output logic             oSOURCE_DATA,
   output logic             oSOURCE_CONT,
   output logic             oRDY
);

   localparam int BANK = 1 << A_BIT;
   localparam int S    = (A_BIT + 2) / 2;
   localparam int TLEN = BANK + LAT;
   localparam int TW   = $clog2(TLEN);
   localparam int SW   = (S > 1) ? $clog2(S) : 1;

   logic          busy_reg, busy_next;
   logic [SW-1:0] s_reg, s_next;
   logic [TW-1:0] t_reg, t_next;

   logic [A_BIT-1:0] t_lo, t_rev, rd_src, coef_next;
   logic             rd_win, we_win;
   int               sh;

   // Sequencer state: one stage is BANK+LAT cycles, stages never overlap.
   always_comb begin
      busy_next = busy_reg;
      s_next    = s_reg;
      t_next    = t_reg;
      if (!busy_reg) begin
         if (iSTART) begin
            busy_next = 1'b1;
            s_next    = '0;
            t_next    = '0;
         end
      end else if (t_reg == TW'(TLEN - 1)) begin
         t_next = '0;
         if (s_reg == SW'(S - 1)) begin
            busy_next = 1'b0;
            s_next    = '0;
         end else begin
            s_next = s_reg + SW'(1);
         end
      end else begin
         t_next = t_reg + TW'(1);
      end
   end

   assign t_lo = t_next[A_BIT-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < A_BIT; gi++) begin : g_rev
         assign t_rev[gi] = t_lo[A_BIT-1-gi];
      end
   endgenerate

   // Outputs are registered from the next state so they line up with (s,t).
   always_comb begin
      rd_win = busy_next && (t_next < TW'(BANK));
      we_win = busy_next && (t_next >= TW'(LAT));
`ifdef FHT_BITREV_EN
      rd_src = (s_next == '0) ? t_rev : t_lo;
`else
      rd_src = t_lo;
`endif
      // Left shift truncated to A_BIT bits drops the bits above 4^s, giving the modulo for free.
      sh        = A_BIT - 2 * int'(s_next);
      coef_next = '0;
      if (rd_win) coef_next = t_lo << sh;
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         busy_reg         <= 1'b0;
         s_reg            <= '0;
         t_reg            <= '0;
         oRDY             <= 1'b1;
         oSOURCE_CONT     <= 1'b0;
         oSOURCE_DATA     <= 1'b0;
         oST_ZERO         <= 1'b0;
         oST_LAST         <= 1'b0;
         oWE_A            <= 1'b0;
         oWE_B            <= 1'b0;
         oADDR_COEF       <= '0;
         oSECTOR          <= '0;
         o2ND_PART_SUBSEC <= 1'b0;
      end else begin
         busy_reg         <= busy_next;
         s_reg            <= s_next;
         t_reg            <= t_next;
         oRDY             <= !busy_next;
         oSOURCE_CONT     <= busy_next;
         oSOURCE_DATA     <= busy_next & s_next[0];
         oST_ZERO         <= busy_next && (s_next == '0);
         oST_LAST         <= busy_next && (s_next == SW'(S - 1));
         oWE_A            <= we_win & s_next[0];
         oWE_B            <= we_win & ~s_next[0];
         oADDR_COEF       <= coef_next;
         oSECTOR          <= coef_next[A_BIT-1:A_BIT-2];
         o2ND_PART_SUBSEC <= coef_next[A_BIT-1];
      end
   end

   // Per-bank read address register and LAT-deep write-address delay line.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [A_BIT-1:0] rd_reg;
         logic [A_BIT-1:0] pipe_reg [LAT];

         always_ff @(posedge iCLK) begin
            if (iRESET) begin
               rd_reg <= '0;
               for (int j = 0; j < LAT; j++) pipe_reg[j] <= '0;
            end else begin
               if (rd_win) rd_reg <= rd_src;
               pipe_reg[0] <= rd_reg;
               for (int j = 1; j < LAT; j++) pipe_reg[j] <= pipe_reg[j-1];
            end
         end
      end
   endgenerate

   assign oADDR_RD_0 = g_bank[0].rd_reg;
   assign oADDR_RD_1 = g_bank[1].rd_reg;
   assign oADDR_RD_2 = g_bank[2].rd_reg;
   assign oADDR_RD_3 = g_bank[3].rd_reg;
   assign oADDR_WR_0 = g_bank[0].pipe_reg[LAT-1];
   assign oADDR_WR_1 = g_bank[1].pipe_reg[LAT-1];
   assign oADDR_WR_2 = g_bank[2].pipe_reg[LAT-1];
   assign oADDR_WR_3 = g_bank[3].pipe_reg[LAT-1];

endmodule

// File: tb/tb_fht_ctrl.sv
// Directed bench for fht_ctrl with A_BIT=4, LAT=4 (3 stages of 20 cycles).
// Expected read order in stage 0 follows FHT_BITREV_EN when that macro is defined.
module tb_fht_ctrl;
   localparam int A_BIT = 4;
   localparam int LAT   = 4;
   localparam int BANK  = 16;
   localparam int S     = 3;
   localparam int TLEN  = BANK + LAT;

   logic       iCLK = 1'b0;
   logic       iRESET, iSTART;
   logic       oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
   logic [1:0] oSECTOR;
   logic [3:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
   logic [3:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
   logic [3:0] oADDR_COEF;
   logic       oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY;

   int checks = 0;
   int errors = 0;

   fht_ctrl #(.A_BIT(A_BIT), .LAT(LAT)) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
      .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
      .oSECTOR(oSECTOR),
      .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
      .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
      .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B),
      .oSOURCE_DATA(oSOURCE_DATA), .oSOURCE_CONT(oSOURCE_CONT), .oRDY(oRDY)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] rev4(input logic [3:0] x);
      return {x[0], x[1], x[2], x[3]};
   endfunction

   task automatic check_idle(input string tag);
      check({tag, " rdy"}, int'(oRDY), 1);
      check({tag, " cont"}, int'(oSOURCE_CONT), 0);
      check({tag, " src"}, int'(oSOURCE_DATA), 0);
      check({tag, " we_a"}, int'(oWE_A), 0);
      check({tag, " we_b"}, int'(oWE_B), 0);
      check({tag, " st_zero"}, int'(oST_ZERO), 0);
      check({tag, " st_last"}, int'(oST_LAST), 0);
      check({tag, " coef"}, int'(oADDR_COEF), 0);
   endtask

   // Starts a run and checks ncyc busy cycles; spur_k re-pulses iSTART while busy.
   task automatic run(input string tag, input int ncyc, input int spur_k, input logic [3:0] prefill);
      logic [3:0] exp_rd, exp_wr, exp_coef;
      logic [3:0] hist[$];
      int s, t, cnt_a[S], cnt_b[S];
      bit brev;
`ifdef FHT_BITREV_EN
      brev = 1'b1;
`else
      brev = 1'b0;
`endif
      exp_rd = prefill;
      hist = {prefill, prefill, prefill, prefill};
      for (int i = 0; i < S; i++) begin cnt_a[i] = 0; cnt_b[i] = 0; end
      iSTART = 1'b1;
      @(posedge iCLK); @(negedge iCLK);
      iSTART = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         s = k / TLEN;
         t = k % TLEN;
         if (t < BANK) exp_rd = (s == 0 && brev) ? rev4(4'(t)) : 4'(t);
         hist.push_back(exp_rd);
         exp_wr = hist.pop_front();
         exp_coef = (t < BANK) ? 4'((t % (4 ** s)) << (A_BIT - 2 * s)) : 4'd0;
         check($sformatf("%s k%0d rdy", tag, k), int'(oRDY), 0);
         check($sformatf("%s k%0d cont", tag, k), int'(oSOURCE_CONT), 1);
         check($sformatf("%s k%0d st_zero", tag, k), int'(oST_ZERO), int'(s == 0));
         check($sformatf("%s k%0d st_last", tag, k), int'(oST_LAST), int'(s == S - 1));
         check($sformatf("%s k%0d src", tag, k), int'(oSOURCE_DATA), s % 2);
         check($sformatf("%s k%0d rd", tag, k),
               int'({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}),
               int'({exp_rd, exp_rd, exp_rd, exp_rd}));
         check($sformatf("%s k%0d wr", tag, k),
               int'({oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3}),
               int'({exp_wr, exp_wr, exp_wr, exp_wr}));
         check($sformatf("%s k%0d coef", tag, k), int'(oADDR_COEF), int'(exp_coef));
         check($sformatf("%s k%0d sector", tag, k), int'(oSECTOR), int'(exp_coef[3:2]));
         check($sformatf("%s k%0d half", tag, k), int'(o2ND_PART_SUBSEC), int'(exp_coef[3]));
         check($sformatf("%s k%0d we_b", tag, k), int'(oWE_B), int'(t >= LAT && s % 2 == 0));
         check($sformatf("%s k%0d we_a", tag, k), int'(oWE_A), int'(t >= LAT && s % 2 == 1));
         if (oWE_A) cnt_a[s]++;
         if (oWE_B) cnt_b[s]++;
         iSTART = (k == spur_k);
         @(negedge iCLK);
      end
      iSTART = 1'b0;
      if (ncyc == S * TLEN) begin
         check({tag, " we_b count st0"}, cnt_b[0], 16);
         check({tag, " we_a count st1"}, cnt_a[1], 16);
         check({tag, " we_b count st2"}, cnt_b[2], 16);
         check({tag, " we_a count st0+st2"}, cnt_a[0] + cnt_a[2], 0);
         check({tag, " we_b count st1"}, cnt_b[1], 0);
         check_idle({tag, " done"});
         check({tag, " hold rd"}, int'(oADDR_RD_0), 15);
         $display("%s: run of %0d cycles checked, errors so far %0d", tag, ncyc, errors);
      end
   endtask

   initial begin
      iRESET = 1'b1;
      iSTART = 1'b0;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_idle("reset");
      check("reset rd", int'(oADDR_RD_2), 0);
      check("reset wr", int'(oADDR_WR_1), 0);
      check("reset sector", int'(oSECTOR), 0);
      iRESET = 1'b0;
      repeat (2) @(negedge iCLK);
      check_idle("idle");

      // Full run with a spurious iSTART in stage 1.
      run("run1", S * TLEN, 30, 4'd0);
      repeat (3) @(negedge iCLK);
      check_idle("after run1");
      check("after run1 wr hold", int'(oADDR_WR_3), 15);

      // Abort mid stage 1 with reset.
      run("run2", 25, -1, 4'd15);
      iRESET = 1'b1;
      @(posedge iCLK); @(negedge iCLK);
      check_idle("abort");
      check("abort rd", int'(oADDR_RD_0), 0);
      check("abort wr", int'(oADDR_WR_0), 0);
      iRESET = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge iCLK);
         check($sformatf("post abort k%0d we", k), int'({oWE_A, oWE_B}), 0);
      end

      run("run3", S * TLEN, -1, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fht_ctrl.md
Name: fht_ctrl

Overview:
- Sequencer for a radix-4 Fast Hartley Transform over 4*2^A_BIT points, stored as 4 parallel RAM banks of 2^A_BIT words, ping-ponged between memory sets A and B.
- After iSTART it steps through all stages and generates read addresses, write addresses, the twiddle-coefficient address, write enables and mux selects for the butterfly datapath.
- It sits between the host/load logic and the butterfly/RAM datapath. oRDY reports idle.

Parameters:
- A_BIT, 8, bank address width; must be even and ≥2. BANK = 2^A_BIT; stage count S = (A_BIT+2)/2.
- LAT, 4, butterfly pipeline latency in cycles between read address and matching write address (≥1).

Ports:
- iCLK  in  1  clock
- iRESET  in  1  synchronous reset, active-high
- iSTART  in  1  start pulse; accepted only when oRDY=1
- oST_ZERO  out  1  busy and stage==0
- oST_LAST  out  1  busy and stage==S-1
- o2ND_PART_SUBSEC  out  1  second half of current butterfly subsection
- oSECTOR  out  2  coefficient quadrant, equal to oADDR_COEF[A_BIT-1:A_BIT-2]
- oADDR_RD_0..3  out  A_BIT each  read address, banks 0..3
- oADDR_WR_0..3  out  A_BIT each  write address, banks 0..3
- oADDR_COEF  out  A_BIT  twiddle ROM address
- oWE_A  out  1  write enable for memory set A
- oWE_B  out  1  write enable for memory set B
- oSOURCE_DATA  out  1  read-set select: 0 = A, 1 = B
- oSOURCE_CONT  out  1  1 = controller owns RAM ports, 0 = host owns them
- oRDY  out  1  1 = idle/done

Behaviour:
- Counters: stage s (0..S-1) and stage time t (0..BANK+LAT-1). Each stage lasts BANK+LAT cycles with no overlap. Total busy time is S*(BANK+LAT) cycles.
- Reset values: oRDY=1. All addresses, oSECTOR, s and t are 0. All other outputs are 0.
- Idle with iSTART=1: on the next edge oRDY goes to 0, oSOURCE_CONT to 1, s=0, t=0.
- iSTART while busy is ignored.
- Read window t<BANK:
  - With FHT_BITREV_EN, stage 0 gives all four oADDR_RD_k = bitrev(t) over A_BIT bits.
  - Without it, and in every other stage, all four oADDR_RD_k = t.
  - Outside the read window, read addresses hold their last value.
- Coefficient address (read window only, otherwise 0):
  - oADDR_COEF = (t mod 4^s) << (A_BIT-2s); it is 0 in stage 0.
  - o2ND_PART_SUBSEC = oADDR_COEF[A_BIT-1].
  - oSECTOR = oADDR_COEF[A_BIT-1:A_BIT-2].
- Write path:
  - oADDR_WR_k equals oADDR_RD_k delayed exactly LAT cycles through a register pipeline.
  - Write window is t in [LAT, LAT+BANK-1], i.e. exactly BANK writes per stage.
  - Even stages write set B (oWE_B=1, oWE_A=0); odd stages write set A. Both enables are 0 outside the window.
- oSOURCE_DATA = s[0] while busy, 0 when idle.
- End of stage: when t=BANK+LAT-1, if s<S-1 then s increments and t=0. If s==S-1, the block returns to idle: oRDY=1, oSOURCE_CONT=0, s=t=0, enables 0.
- oST_ZERO and oST_LAST are 0 when idle.
- Reset mid-operation: returns to the reset state on the next edge. Pipeline registers are cleared and no further WE pulses occur.
- All outputs are registered, with no combinational paths from inputs to outputs.

Optional Feature:
- FHT_BITREV_EN defined: stage-0 read addresses are bit-reversed t (natural-order input).
- FHT_BITREV_EN undefined: stage-0 read addresses are linear t (input pre-ordered by the loader).
- All other behaviour is identical in both builds.

Test Plan:
- A_BIT=4, LAT=4, reset released, iSTART pulsed for 1 cycle -> oRDY low the next cycle and back high exactly 60 cycles later (3 stages × 20).
- Same run, count WE pulses -> 16 oWE_B pulses in stage 0, 16 oWE_A in stage 1, 16 oWE_B in stage 2. oWE_A and oWE_B are never high together.
- With FHT_BITREV_EN, stage 0 -> read addresses follow 0,8,4,12,2,...,15 on all ports. Each oADDR_WR_k matches the read address from 4 cycles earlier.
- Stage 1, t=0..15 -> oADDR_COEF = (t mod 4)<<2, i.e. 0,4,8,12 repeating. o2ND_PART_SUBSEC is 1 for t mod 4 ∈ {2,3}.
- iSTART pulsed mid-run -> no effect; completion time is unchanged.
- iRESET asserted in stage 1 -> next cycle oRDY=1 and all WE low. A new iSTART gives a full 60-cycle run.
